// File: rtl/fir_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_load_pkg
// Description : Shared types and width helpers for the FIR load sequencer.
//               Holds the sequencer state encoding and the functions that
//               size the timing counter, read pointer and fill counts.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_load_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C_ARM = 3'd1,
    COEFF = 3'd2,
    GAP   = 3'd3,
    D_ARM = 3'd4,
    DATA  = 3'd5,
    PAD   = 3'd6,
    STOP  = 3'd7
  } state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to address entries 0..depth-1.
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    return max2(max2(a, b), max2(c, d));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_load_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fir_load_buffer
// Description : Append-only storage for one stream (coefficients or samples).
//               Writes land at index = count, then count increments; writes
//               to a full buffer are ignored. Read data is registered and can
//               be forced to zero so it can drive an output bus directly.
// Ports       : clock, reset_n (sync, active low), clear (empties buffer),
//               wr_en/wr_data (append), rd_en/rd_idx (registered read),
//               rd_clr (zero the read register), rd_data, count, full.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_load_buffer
  import fir_load_pkg::*;
#(
  parameter int DEPTH      = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            rd_en,
  input  logic                            rd_clr,
  input  logic [index_width(DEPTH)-1:0]   rd_idx,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            full
);

  localparam int IDX_W = index_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign full = (count == CNT_W'(DEPTH));

  // Storage carries no reset; contents are meaningless until counted in.
  always_ff @(posedge clock) begin
    if (wr_en && !clear && !full) begin
      mem[IDX_W'(count)] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (wr_en && !full) begin
        count <= count + CNT_W'(1);
      end

      if (rd_clr) begin
        rd_data <= '0;
      end else if (rd_en) begin
        rd_data <= mem[rd_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_load_sequencer
// Description : Replays buffered coefficients and samples into an n_tap_fir
//               serial load interface: coefficient flag + stream, idle gap,
//               data flag + lead-in zeros, samples, LENGTH-1 zero pad, stop.
// Ports       : clock, reset_n (sync, active low)
//               host side : clear, coeff_wr_en/data, data_wr_en/data, start,
//                           busy, done, start_err, overflow, coeff_count,
//                           sample_count
//               FIR side  : load_coefficients_flag, load_data_flag,
//                           stop_data_load_flag, coefficient_out, data_out
// Revision    : 1.0 - initial release
// ============================================================================
module fir_load_sequencer
  import fir_load_pkg::*;
#(
  parameter int LENGTH          = 20,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_SAMPLES     = 64,
  parameter int GAP_CYCLES      = 20,
  parameter int PRE_DATA_CYCLES = 5
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  clear,
  input  logic                                  coeff_wr_en,
  input  logic [DATA_WIDTH-1:0]                 coeff_wr_data,
  input  logic                                  data_wr_en,
  input  logic [DATA_WIDTH-1:0]                 data_wr_data,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  start_err,
  output logic                                  overflow,
  output logic [count_width(LENGTH)-1:0]        coeff_count,
  output logic [count_width(MAX_SAMPLES)-1:0]   sample_count,
  output logic                                  load_coefficients_flag,
  output logic                                  load_data_flag,
  output logic                                  stop_data_load_flag,
  output logic [DATA_WIDTH-1:0]                 coefficient_out,
  output logic [DATA_WIDTH-1:0]                 data_out
);

  // LENGTH >= 2 and PRE_DATA_CYCLES >= 1 are assumed (PAD and D_ARM always
  // occupy at least one cycle). GAP_CYCLES may be 0, in which case GAP is skipped.
  localparam int CNT_W  = count_width(max4(LENGTH, GAP_CYCLES, PRE_DATA_CYCLES, MAX_SAMPLES));
  localparam int PTR_W  = count_width(max2(LENGTH, MAX_SAMPLES));
  localparam int CC_W   = count_width(LENGTH);
  localparam int CIDX_W = index_width(LENGTH);
  localparam int DIDX_W = index_width(MAX_SAMPLES);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic               done_n, start_err_n, overflow_n;
  logic               start_ok;
  logic               coeff_we, data_we, buf_clear;
  logic               c_rd_en, c_rd_clr, d_rd_en, d_rd_clr;
  logic               coeff_full, data_full;

  assign start_ok = (coeff_count == CC_W'(LENGTH)) && (sample_count != '0);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ptr_n       = ptr;
    done_n      = 1'b0;
    start_err_n = 1'b0;
    overflow_n  = overflow;
    coeff_we    = 1'b0;
    data_we     = 1'b0;
    buf_clear   = 1'b0;
    c_rd_en     = 1'b0;
    c_rd_clr    = 1'b0;
    d_rd_en     = 1'b0;
    d_rd_clr    = 1'b0;

    case (state)
      IDLE: begin
        // clear beats start beats writes; an accepted start swallows writes.
        if (clear) begin
          buf_clear  = 1'b1;
          overflow_n = 1'b0;
        end else if (start && start_ok) begin
          state_n = C_ARM;
          ptr_n   = '0;
        end else begin
          start_err_n = start;
          coeff_we    = coeff_wr_en;
          data_we     = data_wr_en;
          if ((coeff_wr_en && coeff_full) || (data_wr_en && data_full)) begin
            overflow_n = 1'b1;
          end
        end
      end
      C_ARM: begin
        state_n = COEFF;
        cnt_n   = CNT_W'(LENGTH - 1);
      end
      COEFF: begin
        if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            cnt_n   = CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_n = D_ARM;
            cnt_n   = CNT_W'(PRE_DATA_CYCLES - 1);
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = D_ARM;
          cnt_n   = CNT_W'(PRE_DATA_CYCLES - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      D_ARM: begin
        if (cnt == '0) begin
          state_n = DATA;
          cnt_n   = CNT_W'(sample_count) - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          state_n = PAD;
          cnt_n   = CNT_W'(LENGTH - 2);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      PAD: begin
        if (cnt == '0) begin
          state_n = STOP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // The shared read pointer restarts for the sample stream.
    if (state_n == D_ARM && state != D_ARM) begin
      ptr_n = '0;
    end

    // Buffer read registers are the output buses, so they are steered by the
    // state being entered: the word fetched now is visible next cycle.
    case (state_n)
      IDLE: begin
        c_rd_clr = 1'b1;
        d_rd_clr = 1'b1;
      end
      C_ARM: begin
        c_rd_clr = 1'b1;
        d_rd_clr = 1'b1;
      end
      COEFF: begin
        c_rd_en = 1'b1;
        ptr_n   = ptr + PTR_W'(1);
      end
      D_ARM:   d_rd_clr = 1'b1;
      DATA: begin
        d_rd_en = 1'b1;
        ptr_n   = ptr + PTR_W'(1);
      end
      PAD:     d_rd_clr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state                  <= IDLE;
      cnt                    <= '0;
      ptr                    <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      start_err              <= 1'b0;
      overflow               <= 1'b0;
      load_coefficients_flag <= 1'b0;
      load_data_flag         <= 1'b0;
      stop_data_load_flag    <= 1'b0;
    end else begin
      state                  <= state_n;
      cnt                    <= cnt_n;
      ptr                    <= ptr_n;
      busy                   <= (state_n != IDLE);
      done                   <= done_n;
      start_err              <= start_err_n;
      overflow               <= overflow_n;
      load_coefficients_flag <= (state_n != IDLE);
      load_data_flag         <= (state_n inside {D_ARM, DATA, PAD, STOP});
      stop_data_load_flag    <= (state_n == STOP);
    end
  end

  fir_load_buffer #(
    .DEPTH      (LENGTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_coeff_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (buf_clear),
    .wr_en   (coeff_we),
    .wr_data (coeff_wr_data),
    .rd_en   (c_rd_en),
    .rd_clr  (c_rd_clr),
    .rd_idx  (CIDX_W'(ptr)),
    .rd_data (coefficient_out),
    .count   (coeff_count),
    .full    (coeff_full)
  );

  fir_load_buffer #(
    .DEPTH      (MAX_SAMPLES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_data_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (buf_clear),
    .wr_en   (data_we),
    .wr_data (data_wr_data),
    .rd_en   (d_rd_en),
    .rd_clr  (d_rd_clr),
    .rd_idx  (DIDX_W'(ptr)),
    .rd_data (data_out),
    .count   (sample_count),
    .full    (data_full)
  );

endmodule
`default_nettype wire

// File: doc/fir_load_sequencer.md
Name: fir_load_sequencer

Overview:
- Drives the n_tap_fir serial load protocol from buffered coefficients and samples: load_coefficients_flag, coefficient stream, load_data_flag, sample stream, LENGTH-1 zero pad, then stop_data_load_flag.
- Sits between a host/register writer and n_tap_fir. Its outputs connect directly to the FIR's clock, flag, coefficient_in and data_in ports.

Parameters:
- LENGTH, 20, FIR tap count; coefficients streamed per run; zero-pad count is LENGTH-1.
- DATA_WIDTH, 8, coefficient and sample width.
- MAX_SAMPLES, 64, sample buffer depth.
- GAP_CYCLES, 20, idle cycles between the last coefficient and load_data_flag rising.
- PRE_DATA_CYCLES, 5, cycles with load_data_flag high and data_out=0 before the first sample.

Ports:
- clock  in  1  system clock, single domain.
- reset_n  in  1  synchronous active-low reset.
- clear  in  1  empties both buffers and clears overflow (IDLE only).
- coeff_wr_en  in  1  write coefficient (IDLE only).
- coeff_wr_data  in  DATA_WIDTH  coefficient value.
- data_wr_en  in  1  write sample (IDLE only).
- data_wr_data  in  DATA_WIDTH  sample value.
- start  in  1  begin sequence.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the sequence completes.
- start_err  out  1  one-cycle pulse when start is rejected.
- overflow  out  1  sticky; set when a write hits a full buffer.
- coeff_count  out  clog2(LENGTH+1)  coefficients stored.
- sample_count  out  clog2(MAX_SAMPLES+1)  samples stored.
- load_coefficients_flag  out  1  to FIR.
- load_data_flag  out  1  to FIR.
- stop_data_load_flag  out  1  to FIR.
- coefficient_out  out  DATA_WIDTH  to FIR coefficient_in.
- data_out  out  DATA_WIDTH  to FIR data_in.

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, both counts 0, overflow 0, FSM to IDLE. Buffer contents are don't-care. Reset mid-sequence aborts immediately; done does not pulse.
- All outputs are registered.
- Writes:
  - Accepted only in IDLE.
  - Entries are stored at index = count, then count increments.
  - A write to a full buffer is dropped and sets overflow.
  - Writes while busy are dropped silently; overflow is not set.
- Priority in IDLE, same cycle: clear > start > writes.
  - clear with start: clear executes, start is ignored, no start_err.
  - An accepted start drops any concurrent write.
- start in IDLE:
  - Accepted iff coeff_count==LENGTH and sample_count>=1.
  - Otherwise start_err pulses for one cycle and the FSM stays in IDLE.
- FSM (each state's outputs appear in the cycles spent in it):
  - IDLE: all flags 0, data buses 0.
  - C_ARM (1 cycle): load_coefficients_flag=1, coefficient_out=0.
  - COEFF (LENGTH cycles): coefficient_out=coeff[0..LENGTH-1] in order.
  - GAP (GAP_CYCLES cycles): coefficient_out holds the last coefficient. If GAP_CYCLES=0 the state is skipped.
  - D_ARM (PRE_DATA_CYCLES cycles): load_data_flag=1, data_out=0.
  - DATA (sample_count cycles): data_out=sample[0..N-1].
  - PAD (LENGTH-1 cycles): data_out=0.
  - STOP (1 cycle): stop_data_load_flag=1.
  - Then IDLE. In the first IDLE cycle done=1 and all flags and buses return to 0.
- Flags stay asserted from their rising state until IDLE.
- Latency from the accepted-start edge to the done pulse: 1+LENGTH+GAP_CYCLES+PRE_DATA_CYCLES+N+(LENGTH-1)+1 cycles.
- Buffers and counts are retained after done, so start re-runs the same stream.
- A single down-counter sized for max(LENGTH, GAP_CYCLES, PRE_DATA_CYCLES, MAX_SAMPLES) times each state. The read pointer increments in COEFF and DATA.

Decomposition:
- Package fir_load_pkg holds:
  - the state enum (IDLE, C_ARM, COEFF, GAP, D_ARM, DATA, PAD, STOP);
  - width functions/constants for the counter and the two counts.
- Sub-module fir_load_buffer:
  - parameters DEPTH and DATA_WIDTH;
  - write port, count, full flag, synchronous read by index;
  - instantiated twice (coefficients with DEPTH=LENGTH, samples with DEPTH=MAX_SAMPLES).

Test Plan:
1. Write coefficients 34,34,0,49,…,159,10 (20 values) and samples 10,20,…,200,140,…,169 (33 values), then start. Required: load_coefficients_flag rises at cycle 1; coefficient_out=34 at cycle 2 and 10 at cycle 21; load_data_flag rises at cycle 42; data_out=10 at cycle 47; 19 zeros follow the last sample; stop flag at cycle 99; done at cycle 100.
2. Start with 19 coefficients loaded, then again with 0 samples loaded. Required: start_err pulses each time, busy stays 0, all flags stay 0.
3. Write 65 samples with MAX_SAMPLES=64. Required: sample_count=64 and overflow=1. Then clear. Required: counts 0 and overflow 0.
4. Deassert reset_n during DATA at sample index 5. Required: next cycle all flags and buses 0, counts 0, no done. A fresh load and start then completes normally.
5. Assert start+clear in the same cycle, then start+data_wr_en in the same cycle with a valid load. Required: first is cleared with no start_err; second starts and sample_count is unchanged.
6. After a completed run, start again without writing. Required: identical output stream; writes attempted while busy are ignored and overflow stays 0.
